// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core with on-the-fly key expansion.
// One block in via valid/ready, ROUNDS rounds of SUB (K sub-cycles) + MIX,
// ciphertext out via valid/ready. SBOX_LANES selects 4 or 16 data S-boxes.
module aes128_enc_iter #(
    parameter int unsigned SBOX_LANES = 16,
    parameter int unsigned ROUNDS     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned K   = 16 / SBOX_LANES;
    localparam int unsigned LIW = (K > 1) ? $clog2(K) : 1;

    // Elaboration-time parameter legality
    if (SBOX_LANES != 4 && SBOX_LANES != 16) begin : g_bad_lanes
        $error("aes128_enc_iter: SBOX_LANES must be 4 or 16");
    end
    if (ROUNDS < 1 || ROUNDS > 10) begin : g_bad_rounds
        $error("aes128_enc_iter: ROUNDS must be in 1..10");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_MIX,
        S_DONE
    } fsm_t;

    // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) general multiply (shift-and-add)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    fsm_t           fsm;
    logic [127:0]   st;
    logic [127:0]   rk;
    logic [3:0]     rnd;
    logic [7:0]     rcon;
    logic [LIW-1:0] lane_idx;

    logic [7:0]     cur    [16];
    logic [7:0]     sb_in  [SBOX_LANES];
    logic [7:0]     sb_out [SBOX_LANES];
    logic [7:0]     sub_b  [16];
    logic [7:0]     sr     [16];
    logic [7:0]     mc     [16];
    logic [127:0]   st_sub;
    logic [127:0]   mix_res;
    logic [127:0]   rk_next;
    logic [31:0]    k_rot;
    logic [31:0]    k_tmp;
    logic [31:0]    nw0;
    logic [31:0]    nw1;
    logic [31:0]    nw2;
    logic [31:0]    nw3;
    logic           last_round;

    // Unpack state into bytes; byte 0 is the MSB, column-major
    always_comb begin
        for (int b = 0; b < 16; b++) begin
            cur[b] = st[8*(15-b) +: 8];
        end
    end

    // Route the bytes of the active lane group to the data S-boxes
    always_comb begin
        for (int j = 0; j < SBOX_LANES; j++) begin
            sb_in[j] = 8'h00;
            for (int b = 0; b < 16; b++) begin
                if ((b / SBOX_LANES) == 32'(lane_idx) && (b % SBOX_LANES) == j) begin
                    sb_in[j] = cur[b];
                end
            end
        end
    end

    // Data S-box bank
    always_comb begin
        for (int j = 0; j < SBOX_LANES; j++) begin
            sb_out[j] = sbox(sb_in[j]);
        end
    end

    // State after substituting the active lane group
    always_comb begin
        st_sub = '0;
        for (int b = 0; b < 16; b++) begin
            sub_b[b] = cur[b];
            if ((b / SBOX_LANES) == 32'(lane_idx)) begin
                sub_b[b] = sb_out[b % SBOX_LANES];
            end
            st_sub[8*(15-b) +: 8] = sub_b[b];
        end
    end

    // Next round key: RotWord, SubWord via 4 key S-boxes, rcon, chained XOR
    always_comb begin
        k_rot   = {rk[23:0], rk[31:24]};
        k_tmp   = {sbox(k_rot[31:24]), sbox(k_rot[23:16]),
                   sbox(k_rot[15:8]),  sbox(k_rot[7:0])} ^ {rcon, 24'h000000};
        nw0     = rk[127:96] ^ k_tmp;
        nw1     = rk[95:64]  ^ nw0;
        nw2     = rk[63:32]  ^ nw1;
        nw3     = rk[31:0]   ^ nw2;
        rk_next = {nw0, nw1, nw2, nw3};
    end

    // ShiftRows, MixColumns (skipped on the final round), AddRoundKey
    always_comb begin
        last_round = (rnd == 4'(ROUNDS));
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = cur[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                      ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1]
                      ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        mix_res = '0;
        for (int b = 0; b < 16; b++) begin
            mix_res[8*(15-b) +: 8] = (last_round ? sr[b] : mc[b]) ^ rk_next[8*(15-b) +: 8];
        end
    end

    // Control FSM and datapath registers; reset aborts any block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= S_IDLE;
            st        <= '0;
            rk        <= '0;
            rnd       <= 4'd0;
            rcon      <= 8'h00;
            lane_idx  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        st       <= in_data ^ in_key;
                        rk       <= in_key;
                        rnd      <= 4'd1;
                        rcon     <= 8'h01;
                        lane_idx <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= S_SUB;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_SUB: begin
                    st <= st_sub;
                    if (lane_idx == LIW'(K - 1)) begin
                        lane_idx <= '0;
                        fsm      <= S_MIX;
                    end else begin
                        lane_idx <= lane_idx + LIW'(1);
                    end
                end
                S_MIX: begin
                    st   <= mix_res;
                    rk   <= rk_next;
                    rcon <= xtime(rcon);
                    if (last_round) begin
                        out_data  <= mix_res;
                        out_valid <= 1'b1;
                        fsm       <= S_DONE;
                    end else begin
                        rnd      <= rnd + 4'd1;
                        lane_idx <= '0;
                        fsm      <= S_SUB;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= S_IDLE;
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Bench for aes128_enc_iter: known-answer vectors, backpressure, back-to-back,
// mid-run reset, post-accept input changes and random blocks vs. a reference model.
module tb_aes128_enc_iter;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    // Per-instance round count and accept-to-valid latency ROUNDS*(16/LANES+1)
    localparam int ROUNDS_OF [3] = '{10, 10, 1};
    localparam int LAT_OF    [3] = '{20, 50, 5};

    logic clk;
    logic rst;
    logic [2:0]        in_valid;
    logic [2:0]        out_ready;
    logic [2:0][127:0] in_data;
    logic [2:0][127:0] in_key;
    wire  [2:0]        in_ready;
    wire  [2:0]        out_valid;
    wire  [2:0]        busy;
    wire  [2:0][127:0] out_data;

    int n_cmp;
    int n_bad;
    logic [7:0] sbt [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes128_enc_iter #(.SBOX_LANES(16), .ROUNDS(10)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_key(in_key[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

    aes128_enc_iter #(.SBOX_LANES(4), .ROUNDS(10)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_key(in_key[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

    aes128_enc_iter #(.SBOX_LANES(4), .ROUNDS(1)) dut_r1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_key(in_key[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int aa;
        p  = 0;
        aa = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
        end
        return 8'(p);
    endfunction

    // S-box from its definition: brute-force inverse then bitwise affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] o;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbt[x] = o;
        end
    endtask

    // Textbook AES on a 4x4 byte matrix with a precomputed word key schedule
    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt,
                                             input int rounds);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ key[127-8*(4*c+r) -: 8];
        for (int rd = 1; rd <= rounds; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = sbt[s[r][c]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = s[r][(c+r)%4];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rd < rounds)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // One full block transfer; called and returns at #1 after a rising edge
    task automatic xfer(input int d, input logic [127:0] key, input logic [127:0] pt,
                        input int hold, input bit scramble,
                        output logic [127:0] ct, output int lat);
        int n;
        in_data[d]   = pt;
        in_key[d]    = key;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b0;
        n = 0;
        while (!in_ready[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", 128'(n < 100), 128'(1'b1));
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        if (scramble) begin
            in_data[d] = '1;
            in_key[d]  = '1;
        end
        chk("busy_after_accept", 128'(busy[d]), 128'(1'b1));
        chk("ready_after_accept", 128'(in_ready[d]), 128'(1'b0));
        lat = 0;
        while (!out_valid[d] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        ct = out_data[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_data", out_data[d], ct);
            chk("bp_flags", 128'({out_valid[d], in_ready[d], busy[d]}), 128'(3'b101));
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        chk("post_hs_flags", 128'({out_valid[d], in_ready[d], busy[d]}), 128'(3'b010));
        chk("post_hs_data", out_data[d], ct);
    endtask

    typedef struct {
        int           d;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
        bit           scramble;
    } vec_t;

    vec_t         tbl [5];
    logic [127:0] ct;
    logic [127:0] exp_ct;
    logic [127:0] rk;
    logic [127:0] rp;
    int           lat;
    int           n;
    bit           seen;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        in_key    = '0;

        tbl[0] = '{d: 0, key: K1, pt: P1, ct: C1, hold: 0, scramble: 1'b0};
        tbl[1] = '{d: 1, key: K2, pt: P2, ct: C2, hold: 0, scramble: 1'b0};
        tbl[2] = '{d: 0, key: K2, pt: P2, ct: C2, hold: 7, scramble: 1'b0};
        tbl[3] = '{d: 1, key: K1, pt: P1, ct: C1, hold: 3, scramble: 1'b1};
        tbl[4] = '{d: 0, key: K1, pt: P1, ct: C1, hold: 0, scramble: 1'b1};

        build_sbox();

        // Reset values while rst is held
        #12;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_flags%0d", d),
                128'({in_ready[d], out_valid[d], busy[d]}), 128'(3'b000));
            chk($sformatf("rst_data%0d", d), out_data[d], 128'h0);
        end
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // Reference model against the published vectors
        chk("model_c1", aes_ref(K1, P1, 10), C1);
        chk("model_c2", aes_ref(K2, P2, 10), C2);

        // Known-answer table: latency, backpressure, post-accept input change
        for (int i = 0; i < 5; i++) begin
            xfer(tbl[i].d, tbl[i].key, tbl[i].pt, tbl[i].hold, tbl[i].scramble, ct, lat);
            chk($sformatf("vec%0d_ct", i), ct, tbl[i].ct);
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(LAT_OF[tbl[i].d]));
        end

        // Back-to-back with in_valid held high and out_ready tied high
        in_data[0]   = P1;
        in_key[0]    = K1;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        n = 0;
        while (!in_ready[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_data[0] = P2;
        in_key[0]  = K2;
        lat = 0;
        while (!out_valid[0] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_ct1", out_data[0], C1);
        chk("b2b_lat1", 128'(lat), 128'(20));
        @(posedge clk); #1;
        chk("b2b_gap", 128'({out_valid[0], in_ready[0], busy[0]}), 128'(3'b010));
        @(posedge clk); #1;
        chk("b2b_accept2", 128'({in_ready[0], busy[0]}), 128'(2'b01));
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_ct2", out_data[0], C2);
        chk("b2b_lat2", 128'(lat), 128'(20));
        @(posedge clk); #1;
        out_ready[0] = 1'b0;

        // Asynchronous reset in the middle of a block
        in_data[0]  = P1;
        in_key[0]   = K1;
        in_valid[0] = 1'b1;
        n = 0;
        while (!in_ready[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_flags", 128'({out_valid[0], busy[0], in_ready[0]}), 128'(3'b000));
        chk("midrst_data", out_data[0], 128'h0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid[0] || busy[0]) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("midrst_no_stale", 128'(seen), 128'(1'b0));
        xfer(0, K1, P1, 0, 1'b0, ct, lat);
        chk("midrst_fresh_ct", ct, C1);
        chk("midrst_fresh_lat", 128'(lat), 128'(20));

        // Random blocks on every instance against the reference model
        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 3; d++) begin
                rk = {$urandom, $urandom, $urandom, $urandom};
                rp = {$urandom, $urandom, $urandom, $urandom};
                exp_ct = aes_ref(rk, rp, ROUNDS_OF[d]);
                xfer(d, rk, rp, int'($urandom_range(0, 2)), 1'b0, ct, lat);
                chk($sformatf("rand%0d_d%0d_ct", i, d), ct, exp_ct);
                chk($sformatf("rand%0d_d%0d_lat", i, d), 128'(lat), 128'(LAT_OF[d]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
